// File: rtl/lpc_pkg.sv
// lpc_pkg: shared register map, reset defaults and FSM state encoding for the LPC autocorrelator.
package lpc_pkg;
    localparam logic [15:0] ADDR_FRAME_LEN  = 16'h0000;
    localparam logic [15:0] ADDR_CTRL       = 16'h0001;
    localparam logic [15:0] ADDR_STATUS     = 16'h0002;
    localparam logic [15:0] ADDR_ZCR_THRESH = 16'h0003;
    localparam logic [15:0] ADDR_SHIFT      = 16'h0004;
    localparam logic [15:0] ADDR_ZCR        = 16'h0005;
    localparam logic [15:0] ADDR_R_BASE     = 16'h0010;
    localparam logic [15:0] RST_FRAME_LEN   = 16'd240;
    localparam logic [15:0] RST_ZCR_THRESH  = 16'd60;
    localparam logic [15:0] RST_SHIFT       = 16'd8;
    typedef enum logic [1:0] {IDLE, SHIFT, MAC, PUBLISH} state_e;
endpackage

// File: rtl/lpc_acorr_regs.sv
// lpc_acorr_regs: register file, result bank and readback scaling for lpc_autocorr.
//   address_i/read_i/write_i/writedata_i/readdata_o : register bus, readdata registered
//   publish_i/acc_i/zcr_i : end-of-frame copy of accumulators and zero-crossing count
//   overrun_i : dropped-sample event
//   frame_len_o/enable_o/clear_o : configuration to the datapath; clear_o is a same-cycle pulse
//   voiced_o : voicing decision of the last published frame
module lpc_acorr_regs
    import lpc_pkg::*;
#(
    parameter int ORDER     = 10,
    parameter int MAX_FRAME = 1024,
    parameter int ACC_W     = 42
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [15:0]             address_i,
    input  logic                    read_i,
    input  logic                    write_i,
    input  logic [15:0]             writedata_i,
    output logic [15:0]             readdata_o,
    input  logic                    publish_i,
    input  logic signed [ACC_W-1:0] acc_i [ORDER+1],
    input  logic [15:0]             zcr_i,
    input  logic                    overrun_i,
    output logic [15:0]             frame_len_o,
    output logic                    enable_o,
    output logic                    clear_o,
    output logic                    voiced_o
);
    logic [15:0] frame_len_q, frame_len_d, thresh_q, thresh_d, shift_q, shift_d;
    logic [15:0] zcr_q, zcr_d, readdata_q, readdata_d, rd_val, r_sat;
    logic enable_q, enable_d, ready_q, ready_d, overrun_q, overrun_d, voiced_q, voiced_d;
    logic wr_fl, wr_ctrl, wr_thr, wr_sh, rd_status, r_hit;
    logic signed [ACC_W-1:0] bank_q [ORDER+1];
    logic signed [ACC_W-1:0] r_sel, r_shr;

    always_comb begin
        wr_fl       = write_i && address_i == ADDR_FRAME_LEN && writedata_i != 16'd0
                      && 32'(writedata_i) <= 32'(MAX_FRAME);
        wr_ctrl     = write_i && address_i == ADDR_CTRL;
        wr_thr      = write_i && address_i == ADDR_ZCR_THRESH;
        wr_sh       = write_i && address_i == ADDR_SHIFT && 32'(writedata_i) <= 32'(ACC_W - 16);
        rd_status   = read_i && address_i == ADDR_STATUS;
        frame_len_d = wr_fl ? writedata_i : frame_len_q;
        enable_d    = wr_ctrl ? writedata_i[0] : enable_q;
        thresh_d    = wr_thr ? writedata_i : thresh_q;
        shift_d     = wr_sh ? writedata_i : shift_q;
        // a set event in the same cycle as a STATUS read keeps the bit set
        ready_d     = publish_i | (ready_q & ~rd_status);
        overrun_d   = overrun_i | (overrun_q & ~rd_status);
        zcr_d       = publish_i ? zcr_i : zcr_q;
        voiced_d    = publish_i ? (zcr_i < thresh_q) : voiced_q;
        r_sel       = '0;
        r_hit       = 1'b0;
        for (int k = 0; k <= ORDER; k++) begin
            if (address_i == ADDR_R_BASE + 16'(k)) begin
                r_sel = bank_q[k];
                r_hit = 1'b1;
            end
        end
        r_shr = r_sel >>> shift_q;
        // fits in 16 bits only when every bit above bit 15 matches the sign bit
        r_sat = (r_shr[ACC_W-1:15] == {(ACC_W-15){r_shr[15]}}) ? r_shr[15:0] :
                (r_shr[ACC_W-1] ? 16'h8000 : 16'h7fff);
        rd_val = address_i == ADDR_FRAME_LEN  ? frame_len_q :
                 address_i == ADDR_CTRL       ? {15'd0, enable_q} :
                 address_i == ADDR_STATUS     ? {13'd0, voiced_q, overrun_q, ready_q} :
                 address_i == ADDR_ZCR_THRESH ? thresh_q :
                 address_i == ADDR_SHIFT      ? shift_q :
                 address_i == ADDR_ZCR        ? zcr_q :
                 r_hit                        ? r_sat : 16'd0;
        readdata_d = read_i ? rd_val : readdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_len_q <= RST_FRAME_LEN;
            enable_q    <= 1'b1;
            thresh_q    <= RST_ZCR_THRESH;
            shift_q     <= RST_SHIFT;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            zcr_q       <= '0;
            voiced_q    <= 1'b0;
            readdata_q  <= '0;
            for (int k = 0; k <= ORDER; k++) bank_q[k] <= '0;
        end else begin
            frame_len_q <= frame_len_d;
            enable_q    <= enable_d;
            thresh_q    <= thresh_d;
            shift_q     <= shift_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            zcr_q       <= zcr_d;
            voiced_q    <= voiced_d;
            readdata_q  <= readdata_d;
            for (int k = 0; k <= ORDER; k++) bank_q[k] <= publish_i ? acc_i[k] : bank_q[k];
        end
    end

    assign readdata_o  = readdata_q;
    assign frame_len_o = frame_len_q;
    assign enable_o    = enable_q;
    assign clear_o     = wr_ctrl & writedata_i[1];
    assign voiced_o    = voiced_q;
endmodule

// File: rtl/lpc_autocorr.sv
// lpc_autocorr: frame-based autocorrelation R[0..ORDER] and zero-crossing voicing detector.
//   clk/rst : system clock, synchronous active-high reset
//   x/v : signed sample and its one-cycle strobe
//   address/read/write/writedata/readdata : register bus (see lpc_pkg for the map)
//   frame_done : one-cycle pulse when a result bank is published
//   voiced : voicing decision of the last completed frame
//   busy : high while a sample is being shifted and multiplied in
module lpc_autocorr
    import lpc_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ORDER     = 10,
    parameter int MAX_FRAME = 1024,
    parameter int ACC_W     = 2*DATA_W + $clog2(MAX_FRAME)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     v,
    input  logic [15:0]              address,
    input  logic                     read,
    input  logic                     write,
    input  logic [15:0]              writedata,
    output logic [15:0]              readdata,
    output logic                     frame_done,
    output logic                     voiced,
    output logic                     busy
);
    localparam int KW = $clog2(ORDER + 1);

    if (ACC_W < 2*DATA_W + $clog2(MAX_FRAME)) begin : g_acc_w_chk
        $error("ACC_W too narrow for full-precision accumulation");
    end
    if (ORDER < 1 || ORDER > 30) begin : g_order_chk
        $error("ORDER must be within 1..30");
    end

    state_e state_q;
    logic signed [DATA_W-1:0] x_q, h_k;
    logic signed [DATA_W-1:0] hist_q [ORDER+1];
    logic signed [ACC_W-1:0] acc_q [ORDER+1];
    logic signed [ACC_W-1:0] acc_nx [ORDER+1];
    logic signed [2*DATA_W-1:0] prod;
    logic [KW-1:0] k_q;
    logic [15:0] cnt_q, len_q, zcr_q, frame_len;
    logic frame_done_q, busy_q, enable, clear, accept, last_mac, publish, overrun;

    always_comb begin
        h_k = '0;
        for (int k = 0; k <= ORDER; k++) if (k_q == KW'(k)) h_k = hist_q[k];
        prod   = (2*DATA_W)'(hist_q[0]) * (2*DATA_W)'(h_k);
        acc_nx = acc_q;
        for (int k = 0; k <= ORDER; k++)
            if (state_q == MAC && k_q == KW'(k)) acc_nx[k] = acc_q[k] + ACC_W'(prod);
        accept   = state_q == IDLE && v && enable && !clear;
        last_mac = state_q == MAC && k_q == KW'(ORDER);
        // the bank takes acc_nx so the final MAC term lands in the published results
        publish  = last_mac && cnt_q == len_q && !clear;
        overrun  = state_q != IDLE && v && enable && !clear;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q      <= IDLE;
            x_q          <= '0;
            k_q          <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            zcr_q        <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int k = 0; k <= ORDER; k++) begin
                hist_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        x_q     <= x;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                        // frame length is frozen at the first sample of each frame
                        if (cnt_q == 16'd0) len_q <= frame_len;
                    end
                end
                SHIFT: begin
                    hist_q[0] <= x_q;
                    for (int k = 1; k <= ORDER; k++) hist_q[k] <= hist_q[k-1];
                    cnt_q <= cnt_q + 16'd1;
                    if (cnt_q != 16'd0 && x_q[DATA_W-1] != hist_q[0][DATA_W-1]) zcr_q <= zcr_q + 16'd1;
                    k_q     <= '0;
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= acc_nx;
                    k_q   <= k_q + 1'b1;
                    if (last_mac) begin
                        busy_q       <= 1'b0;
                        frame_done_q <= cnt_q == len_q;
                        state_q      <= cnt_q == len_q ? PUBLISH : IDLE;
                    end
                end
                PUBLISH: begin
                    frame_done_q <= 1'b0;
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    zcr_q        <= '0;
                    k_q          <= '0;
                    for (int k = 0; k <= ORDER; k++) begin
                        hist_q[k] <= '0;
                        acc_q[k]  <= '0;
                    end
                end
            endcase
        end
    end

    lpc_acorr_regs #(
        .ORDER     (ORDER),
        .MAX_FRAME (MAX_FRAME),
        .ACC_W     (ACC_W)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .address_i   (address),
        .read_i      (read),
        .write_i     (write),
        .writedata_i (writedata),
        .readdata_o  (readdata),
        .publish_i   (publish),
        .acc_i       (acc_nx),
        .zcr_i       (zcr_q),
        .overrun_i   (overrun),
        .frame_len_o (frame_len),
        .enable_o    (enable),
        .clear_o     (clear),
        .voiced_o    (voiced)
    );

    assign frame_done = frame_done_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_lpc_autocorr.sv
// tb_lpc_autocorr: self-checking bench for lpc_autocorr against a sample-list autocorrelation model.
module tb_lpc_autocorr;
    localparam int ORDER = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] x = '0;
    logic v = 1'b0;
    logic [15:0] address = '0;
    logic read = 1'b0;
    logic write = 1'b0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic frame_done, voiced, busy;
    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int samp[$];

    always #5 clk = ~clk;

    lpc_autocorr #(
        .DATA_W    (16),
        .ORDER     (ORDER),
        .MAX_FRAME (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .v          (v),
        .address    (address),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .frame_done (frame_done),
        .voiced     (voiced),
        .busy       (busy)
    );

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        address = a;
        read = 1'b1;
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    // Autocorrelation of the recorded frame: sum over n of s[n]*s[n-k], scaled and saturated.
    function automatic logic [15:0] model_r(input int k, input int sh);
        longint acc = 0;
        longint r;
        for (int n = k; n < samp.size(); n++) acc += longint'(samp[n]) * longint'(samp[n-k]);
        r = acc >>> sh;
        return r > 32767 ? 16'h7fff : r < -32768 ? 16'h8000 : 16'(r);
    endfunction

    function automatic int model_zcr();
        int z = 0;
        for (int n = 1; n < samp.size(); n++) if ((samp[n] < 0) != (samp[n-1] < 0)) z++;
        return z;
    endfunction

    // One accepted sample: busy for ORDER+2 cycles, then frame_done exactly when it closes the frame.
    task automatic send(input logic signed [15:0] val, input bit last, input int gap);
        x = val;
        v = 1'b1;
        tick();
        v = 1'b0;
        for (int c = 1; c <= ORDER + 2; c++) begin
            checks++;
            if ({busy, frame_done} !== 2'b10) begin
                errors++;
                $display("FAIL send_busy c=%0d: busy=%b frame_done=%b, want busy=1 frame_done=0", c, busy, frame_done);
            end
            tick();
        end
        checks++;
        if ({busy, frame_done} !== {1'b0, last}) begin
            errors++;
            $display("FAIL send_end: busy=%b frame_done=%b, want busy=0 frame_done=%b", busy, frame_done, last);
        end
        if (last) tick();
        repeat (gap) tick();
        samp.push_back(int'(val));
    endtask

    task automatic test_reset();
        logic [15:0] ra [9] = '{16'h00, 16'h01, 16'h02, 16'h03, 16'h04, 16'h05, 16'h10, 16'h1a, 16'h40};
        logic [15:0] re [9] = '{16'd240, 16'd1, 16'd0, 16'd60, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0};
        logic [15:0] d;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({busy, frame_done, voiced} !== 3'b000 || readdata !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b fd=%b voiced=%b rdata=%h, want all 0", busy, frame_done, voiced, readdata);
        end
        for (int i = 0; i < 9; i++) begin
            rd(ra[i], d);
            checks++;
            if (d !== re[i]) begin
                errors++;
                $display("FAIL reset_reg[%h]: got %h want %h", ra[i], d, re[i]);
            end
        end
    endtask

    task automatic test_constant();
        int fd0 = fd_cnt;
        logic [15:0] d;
        for (int i = 0; i < 240; i++) send(16'sd100, i == 239, 0);
        checks++;
        if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL const_fd: got %0d pulses want 1", fd_cnt - fd0); end
        rd(16'h10, d);
        checks++;
        if (d !== 16'd9375) begin errors++; $display("FAIL const_r0: got %0d want 9375", d); end
        repeat (2) tick();
        checks++;
        if (readdata !== 16'd9375) begin errors++; $display("FAIL const_hold: got %0d want 9375", readdata); end
        rd(16'h1a, d);
        checks++;
        if (d !== 16'd8984) begin errors++; $display("FAIL const_r10: got %0d want 8984", d); end
        rd(16'h05, d);
        checks++;
        if (d !== 16'd0) begin errors++; $display("FAIL const_zcr: got %0d want 0", d); end
        checks++;
        if (voiced !== 1'b1) begin errors++; $display("FAIL const_voiced: got %b want 1", voiced); end
        rd(16'h02, d);
        checks++;
        if (d !== 16'h5) begin errors++; $display("FAIL const_status: got %h want 5", d); end
        rd(16'h02, d);
        checks++;
        if (d !== 16'h4) begin errors++; $display("FAIL const_status_reread: got %h want 4", d); end
    endtask

    task automatic test_alternating();
        int fd0 = fd_cnt;
        logic [15:0] d;
        wr(16'h00, 16'd16);
        wr(16'h03, 16'd8);
        wr(16'h04, 16'd16);
        for (int i = 0; i < 16; i++) send(i % 2 ? -16'sd1000 : 16'sd1000, i == 15, 0);
        checks++;
        if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL alt_fd: got %0d pulses want 1", fd_cnt - fd0); end
        rd(16'h05, d);
        checks++;
        if (d !== 16'd15) begin errors++; $display("FAIL alt_zcr: got %0d want 15", d); end
        checks++;
        if (voiced !== 1'b0) begin errors++; $display("FAIL alt_voiced: got %b want 0", voiced); end
        rd(16'h10, d);
        checks++;
        if (d !== 16'd244) begin errors++; $display("FAIL alt_r0: got %0d want 244", d); end
        rd(16'h11, d);
        checks++;
        if (d !== 16'hff1b) begin errors++; $display("FAIL alt_r1: got %h want ff1b (-229)", d); end
        rd(16'h02, d);
        checks++;
        if (d !== 16'h1) begin errors++; $display("FAIL alt_status: got %h want 1", d); end
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        wr(16'h00, 16'd240);
        wr(16'h04, 16'd0);
        for (int i = 0; i < 240; i++) send(16'sd32767, i == 239, 0);
        rd(16'h10, d);
        checks++;
        if (d !== 16'h7fff) begin errors++; $display("FAIL sat_pos_r0: got %h want 7fff", d); end
        for (int i = 0; i < 240; i++) send(-16'sd32768, i == 239, 0);
        rd(16'h11, d);
        checks++;
        if (d !== 16'h7fff) begin errors++; $display("FAIL sat_neg_r1: got %h want 7fff", d); end
        wr(16'h00, 16'd16);
        for (int i = 0; i < 16; i++) send(i % 2 ? -16'sd32768 : 16'sd32767, i == 15, 0);
        rd(16'h11, d);
        checks++;
        if (d !== 16'h8000) begin errors++; $display("FAIL sat_low_r1: got %h want 8000", d); end
    endtask

    task automatic test_overrun();
        int fd0;
        logic [15:0] d;
        rd(16'h02, d);
        wr(16'h00, 16'd2);
        fd0 = fd_cnt;
        x = 16'sd3;
        v = 1'b1;
        tick();
        v = 1'b0;
        repeat (4) tick();
        x = 16'sd7;
        v = 1'b1;
        tick();
        v = 1'b0;
        repeat (ORDER) tick();
        samp.delete();
        rd(16'h02, d);
        checks++;
        if (d !== 16'h2) begin errors++; $display("FAIL ovr_status: got %h want 2", d); end
        rd(16'h02, d);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL ovr_status_reread: got %h want 0", d); end
        send(16'sd5, 1'b1, 0);
        checks++;
        if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL ovr_fd: got %0d pulses want 1", fd_cnt - fd0); end
        rd(16'h10, d);
        checks++;
        if (d !== 16'd34) begin errors++; $display("FAIL ovr_r0: got %0d want 34", d); end
        rd(16'h11, d);
        checks++;
        if (d !== 16'd15) begin errors++; $display("FAIL ovr_r1: got %0d want 15", d); end
    endtask

    task automatic test_clear();
        int fd0 = fd_cnt;
        logic [15:0] d;
        wr(16'h00, 16'd240);
        for (int i = 0; i < 100; i++) send(16'sd100, 1'b0, 0);
        address = 16'h01;
        writedata = 16'h3;
        write = 1'b1;
        x = 16'sd999;
        v = 1'b1;
        tick();
        write = 1'b0;
        v = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL clr_drop: busy=%b want 0", busy); end
        checks++;
        if (fd_cnt != fd0) begin errors++; $display("FAIL clr_fd: got %0d pulses want 0", fd_cnt - fd0); end
        rd(16'h10, d);
        checks++;
        if (d !== 16'd34) begin errors++; $display("FAIL clr_bank_r0: got %0d want 34", d); end
        rd(16'h11, d);
        checks++;
        if (d !== 16'd15) begin errors++; $display("FAIL clr_bank_r1: got %0d want 15", d); end
        rd(16'h02, d);
        checks++;
        if (d !== 16'h5) begin errors++; $display("FAIL clr_status: got %h want 5", d); end
        wr(16'h04, 16'd8);
        for (int i = 0; i < 240; i++) send(16'sd100, i == 239, 0);
        checks++;
        if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL clr_fd_after: got %0d pulses want 1", fd_cnt - fd0); end
        rd(16'h10, d);
        checks++;
        if (d !== 16'd9375) begin errors++; $display("FAIL clr_r0: got %0d want 9375", d); end
        rd(16'h1a, d);
        checks++;
        if (d !== 16'd8984) begin errors++; $display("FAIL clr_r10: got %0d want 8984", d); end
        rd(16'h02, d);
        checks++;
        if (d !== 16'h5) begin errors++; $display("FAIL clr_status_after: got %h want 5", d); end
    endtask

    task automatic test_reset_mid_mac();
        int fd0;
        logic [15:0] d;
        wr(16'h00, 16'd5);
        fd0 = fd_cnt;
        for (int i = 0; i < 4; i++) send(16'sd1000, 1'b0, 0);
        x = 16'sd1000;
        v = 1'b1;
        tick();
        v = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, frame_done, voiced} !== 3'b000 || readdata !== 16'd0) begin
            errors++;
            $display("FAIL rstmac_outputs: busy=%b fd=%b voiced=%b rdata=%h, want all 0", busy, frame_done, voiced, readdata);
        end
        repeat (20) tick();
        checks++;
        if (fd_cnt != fd0) begin errors++; $display("FAIL rstmac_fd: got %0d pulses want 0", fd_cnt - fd0); end
        rd(16'h00, d);
        checks++;
        if (d !== 16'd240) begin errors++; $display("FAIL rstmac_len: got %0d want 240", d); end
        rd(16'h10, d);
        checks++;
        if (d !== 16'd0) begin errors++; $display("FAIL rstmac_r0: got %0d want 0", d); end
        rd(16'h02, d);
        checks++;
        if (d !== 16'h0) begin errors++; $display("FAIL rstmac_status: got %h want 0", d); end
        rd(16'h04, d);
        checks++;
        if (d !== 16'd8) begin errors++; $display("FAIL rstmac_shift: got %0d want 8", d); end
    endtask

    task automatic test_random();
        logic [15:0] d;
        for (int f = 0; f < 5; f++) begin
            int len = $urandom_range(12, 40);
            int sh = $urandom_range(0, 20);
            int thr = $urandom_range(0, 25);
            int mode = $urandom_range(0, 2);
            int fd0, z;
            bit vx;
            wr(16'h00, 16'(len));
            wr(16'h04, 16'(sh));
            wr(16'h03, 16'(thr));
            rd(16'h02, d);
            samp.delete();
            fd0 = fd_cnt;
            for (int i = 0; i < len; i++) begin
                int r = mode == 0 ? int'($signed(16'($urandom))) :
                        mode == 1 ? int'($urandom_range(0, 400)) - 200 : int'($urandom_range(0, 32767));
                send(16'(r), i == len - 1, $urandom_range(0, 2));
            end
            z = model_zcr();
            vx = z < thr;
            checks++;
            if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL rnd_fd f=%0d: got %0d pulses want 1", f, fd_cnt - fd0); end
            for (int k = 0; k <= ORDER; k++) begin
                rd(16'h10 + 16'(k), d);
                checks++;
                if (d !== model_r(k, sh)) begin
                    errors++;
                    $display("FAIL rnd_r f=%0d k=%0d: got %h want %h", f, k, d, model_r(k, sh));
                end
            end
            rd(16'h05, d);
            checks++;
            if (d !== 16'(z)) begin errors++; $display("FAIL rnd_zcr f=%0d: got %0d want %0d", f, d, z); end
            checks++;
            if (voiced !== vx) begin errors++; $display("FAIL rnd_voiced f=%0d: got %b want %b", f, voiced, vx); end
            rd(16'h02, d);
            checks++;
            if (d !== {13'd0, vx, 2'b01}) begin errors++; $display("FAIL rnd_status f=%0d: got %h want %h", f, d, {13'd0, vx, 2'b01}); end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_alternating();
        test_saturation();
        test_overrun();
        test_clear();
        test_reset_mid_mac();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lpc_autocorr.md
LPC_AUTOCORR -- requirements
Module: lpc_autocorr

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed).
REQ-002 SHALL have parameter ORDER, default 10, highest lag computed (R[0]..R[ORDER]), legal 1..30.
REQ-003 SHALL have parameter MAX_FRAME, default 1024, largest legal frame length.
REQ-004 SHALL have parameter ACC_W, default 2*DATA_W+$clog2(MAX_FRAME), accumulator width; elaboration SHALL fail if smaller.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 x  in  DATA_W  signed input sample, sampled when v=1.
REQ-008 v  in  1  one-cycle sample strobe.
REQ-009 address  in  16  register word address.
REQ-010 read  in  1  register read strobe.
REQ-011 write  in  1  register write strobe.
REQ-012 writedata  in  16  register write data.
REQ-013 readdata  out  16  registered read data.
REQ-014 frame_done  out  1  one-cycle pulse when a new result bank is published.
REQ-015 voiced  out  1  voicing decision of last completed frame.
REQ-016 busy  out  1  high while MAC sequence in progress.

Function
REQ-017 Register map SHALL be: 0x00 FRAME_LEN (RW, 1..MAX_FRAME); 0x01 CTRL (W: bit0 enable RW, bit1 clear self-clearing); 0x02 STATUS (R: bit0 frame_ready, bit1 overrun, bit2 voiced); 0x03 ZCR_THRESH (RW); 0x04 SHIFT (RW, 0..ACC_W-16); 0x05 ZCR (R, last frame); 0x10+k R[k] scaled (R, k=0..ORDER); other addresses read 0, writes ignored.
REQ-018 Writes of 0 or >MAX_FRAME to FRAME_LEN SHALL be ignored; legal writes take effect at next frame start, not mid-frame.
REQ-019 readdata SHALL be valid the cycle after read=1 and hold until next read.
REQ-020 Reading STATUS SHALL clear frame_ready and overrun; a set event in the same cycle SHALL win (bit stays 1).
REQ-021 FSM states IDLE, SHIFT, MAC, PUBLISH; IDLE->SHIFT on v=1 and enable=1; SHIFT->MAC next cycle; MAC lasts ORDER+1 cycles; MAC->PUBLISH if sample count reached FRAME_LEN else ->IDLE; PUBLISH->IDLE after 1 cycle.
REQ-022 SHIFT SHALL push x into an ORDER+1 history line, h[0] newest; MAC cycle k SHALL do acc[k] += h[0]*h[k] with full-precision signed product.
REQ-023 Frames SHALL be non-overlapping rectangular: history and accumulators zero at each frame start.
REQ-024 ZCR SHALL count sign changes (sign bit of x differs from previous in-frame sample) within the frame; first sample of a frame never counts.
REQ-025 PUBLISH SHALL copy acc[0..ORDER] and ZCR to the result bank, set voiced = (ZCR < ZCR_THRESH), set frame_ready, pulse frame_done, zero accumulators, history, counters.
REQ-026 R[k] readback SHALL be bank[k] arithmetic-shifted right by SHIFT, saturated to [-32768, 32767].
REQ-027 v=1 while not IDLE (busy) SHALL drop the sample and set overrun; v with enable=0 SHALL be ignored without overrun.
REQ-028 CTRL.clear SHALL abort the current frame (return to IDLE, zero acc, history, counters) and leave the result bank, voiced and STATUS unchanged; clear and v in same cycle: clear wins, sample dropped.
REQ-029 busy latency: sample at cycle t produces busy over t+1..t+ORDER+2; frame_done at t+ORDER+3 for the last sample.

Reset
REQ-030 rst SHALL set FRAME_LEN=240, enable=1, ZCR_THRESH=60, SHIFT=8, STATUS=0, result bank=0, ZCR=0, readdata=0, voiced=0, frame_done=0, busy=0, FSM=IDLE, acc/history/counters=0.
REQ-031 rst mid-frame or mid-MAC SHALL abort with no publish and no partial results visible.

Structure
REQ-032 A shared package lpc_pkg SHALL hold register address constants, reset defaults (240, 60, 8) and the FSM state enum.
REQ-033 The register file/Avalon decode SHALL be one sub-module lpc_acorr_regs; MAC datapath and FSM stay in lpc_autocorr.

Verification
REQ-034 Constant x=100, FRAME_LEN=240, SHIFT=8: R[0]=2400000>>8=9375, R[10]=2300000>>8=8984, ZCR=0, voiced=1, frame_done once.
REQ-035 Alternating +1000/-1000, FRAME_LEN=16, ZCR_THRESH=8, SHIFT=16: ZCR=15, voiced=0, R[0]=16000000>>16=244, R[1]=-15000000>>16=-229.
REQ-036 x=32767, FRAME_LEN=240, SHIFT=0 -> R[0] reads 32767 (saturated); x=-32768 -> R[1] reads 32767.
REQ-037 Two v strobes 5 cycles apart (ORDER=10) -> second dropped, STATUS=0x2, sample count advances by 1; STATUS re-read -> 0x0.
REQ-038 CTRL.clear after 100 of 240 samples, then 240 samples of x=100 -> results match REQ-034; prior bank readable unchanged until publish.
REQ-039 rst asserted during MAC -> all outputs and registers at REQ-030 values next cycle; FRAME_LEN reads 240.
